// File: rtl/slip_frame_decoder_if.sv
// Byte-wide AXI-style stream bundle shared by the SLIP decoder and its neighbours.
// Source drives data/valid/last/user; Sink returns ready.
interface axis_interface;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport Source (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport Sink (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/slip_frame_decoder.sv
// SLIP (RFC 1055) de-framer: raw UART bytes in, decoded payload packets out.
// One-byte hold stage lets tlast land on the final payload byte of a frame.
module slip_frame_decoder #(
    parameter int         MAX_FRAME_LEN = 256,
    parameter logic [7:0] END_CHAR      = 8'hC0,
    parameter logic [7:0] ESC_CHAR      = 8'hDB,
    parameter logic [7:0] ESC_END       = 8'hDC,
    parameter logic [7:0] ESC_ESC       = 8'hDD
) (
    input  logic          clk,
    input  logic          reset_n,
    axis_interface.Sink   rx_stream,
    axis_interface.Source frame_stream,
    output logic          frame_error,
    output logic          frame_overflow
);

    localparam int            CW   = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {
        HUNT,
        IDLE,
        DATA,
        ESC
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [7:0]    h_q;
    logic          hv_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_n;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          o_last;
    logic          o_user;

    logic          take;
    logic          d_vld;
    logic [7:0]    d_byte;
    logic          mv;
    logic          mv_last;
    logic          mv_user;
    logic          load;
    logic          err_n;
    logic          ovf_n;
    logic [7:0]    b;
    logic          unused_rx;

    assign unused_rx = ^{rx_stream.tlast, rx_stream.tuser};

    assign rx_stream.tready = !hv_q || !o_valid || frame_stream.tready;
    assign take             = rx_stream.tvalid && rx_stream.tready;
    assign b                = rx_stream.tdata;

    assign frame_stream.tdata  = o_data;
    assign frame_stream.tvalid = o_valid;
    assign frame_stream.tlast  = o_last;
    assign frame_stream.tuser  = o_user;

    always_comb begin
        state_n = state;
        cnt_n   = cnt_q;
        d_vld   = 1'b0;
        d_byte  = b;
        mv      = 1'b0;
        mv_last = 1'b0;
        mv_user = 1'b0;
        load    = 1'b0;
        err_n   = 1'b0;
        ovf_n   = 1'b0;
        if (take) begin
            unique case (state)
                HUNT: begin
                    if (b == END_CHAR) state_n = IDLE;
                end
                IDLE: begin
                    unique case (1'b1)
                        (b == END_CHAR): ;
                        (b == ESC_CHAR): state_n = ESC;
                        default: begin
                            d_vld   = 1'b1;
                            state_n = DATA;
                        end
                    endcase
                end
                DATA: begin
                    unique case (1'b1)
                        (b == END_CHAR): begin
                            mv      = hv_q;
                            mv_last = 1'b1;
                            cnt_n   = '0;
                            state_n = IDLE;
                        end
                        (b == ESC_CHAR): state_n = ESC;
                        default:         d_vld   = 1'b1;
                    endcase
                end
                ESC: begin
                    unique case (1'b1)
                        (b == ESC_END): begin
                            d_vld   = 1'b1;
                            d_byte  = END_CHAR;
                            state_n = DATA;
                        end
                        (b == ESC_ESC): begin
                            d_vld   = 1'b1;
                            d_byte  = ESC_CHAR;
                            state_n = DATA;
                        end
                        default: begin
                            // Bad escape: flush what we hold as a bad frame
                            err_n   = 1'b1;
                            mv      = hv_q;
                            mv_last = 1'b1;
                            mv_user = 1'b1;
                            cnt_n   = '0;
                            state_n = (b == END_CHAR) ? IDLE : HUNT;
                        end
                    endcase
                end
                default: state_n = HUNT;
            endcase

            if (d_vld) begin
                if (cnt_q == CMAX) begin
                    ovf_n   = 1'b1;
                    mv      = hv_q;
                    mv_last = 1'b1;
                    mv_user = 1'b1;
                    cnt_n   = '0;
                    state_n = HUNT;
                end else begin
                    mv    = hv_q;
                    load  = 1'b1;
                    cnt_n = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= HUNT;
            h_q            <= '0;
            hv_q           <= 1'b0;
            cnt_q          <= '0;
            o_data         <= '0;
            o_valid        <= 1'b0;
            o_last         <= 1'b0;
            o_user         <= 1'b0;
            frame_error    <= 1'b0;
            frame_overflow <= 1'b0;
        end else begin
            state          <= state_n;
            cnt_q          <= cnt_n;
            frame_error    <= err_n;
            frame_overflow <= ovf_n;
            if (load) begin
                h_q  <= d_byte;
                hv_q <= 1'b1;
            end else if (mv) begin
                hv_q <= 1'b0;
            end
            // Reload wins over the downstream handshake in the same cycle
            if (mv) begin
                o_valid <= 1'b1;
                o_data  <= h_q;
                o_last  <= mv_last;
                o_user  <= mv_user;
            end else if (o_valid && frame_stream.tready) begin
                o_valid <= 1'b0;
                o_data  <= '0;
                o_last  <= 1'b0;
                o_user  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_slip_frame_decoder.sv
// Scoreboard bench for slip_frame_decoder: reference SLIP decoder feeds an
// expected-beat queue, a monitor pops and compares on each output handshake.
module tb_slip_frame_decoder;

    localparam int MAXL = 4;
    localparam int S_HUNT = 0;
    localparam int S_IDLE = 1;
    localparam int S_DATA = 2;
    localparam int S_ESC  = 3;

    logic clk;
    logic rst_n;
    logic ferr;
    logic fovf;

    axis_interface rx ();
    axis_interface fs ();

    slip_frame_decoder #(.MAX_FRAME_LEN(MAXL)) dut (
        .clk            (clk),
        .reset_n        (rst_n),
        .rx_stream      (rx),
        .frame_stream   (fs),
        .frame_error    (ferr),
        .frame_overflow (fovf)
    );

    int checks = 0;
    int fails = 0;
    int beats_exp = 0;
    int beats_seen = 0;
    int exp_err = 0;
    int seen_err = 0;
    int exp_ovf = 0;
    int seen_ovf = 0;
    logic rnd_rdy = 1'b0;
    logic [9:0] exp_q[$];

    int m_state;
    logic m_hv;
    logic [7:0] m_h;
    int m_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        fs.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            fs.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic emit(input logic last, input logic user);
        exp_q.push_back({m_h, last, user});
        beats_exp++;
        m_hv = 1'b0;
    endtask

    task automatic mdl(input logic [7:0] b);
        logic [7:0] d;
        logic dv;
        d = b;
        dv = 1'b0;
        case (m_state)
            S_HUNT: if (b == 8'hC0) m_state = S_IDLE;
            S_IDLE: begin
                if (b == 8'hDB) m_state = S_ESC;
                else if (b != 8'hC0) begin
                    dv = 1'b1;
                    m_state = S_DATA;
                end
            end
            S_DATA: begin
                if (b == 8'hC0) begin
                    if (m_hv) emit(1'b1, 1'b0);
                    m_cnt = 0;
                    m_state = S_IDLE;
                end else if (b == 8'hDB) m_state = S_ESC;
                else dv = 1'b1;
            end
            default: begin
                if (b == 8'hDC || b == 8'hDD) begin
                    d = (b == 8'hDC) ? 8'hC0 : 8'hDB;
                    dv = 1'b1;
                    m_state = S_DATA;
                end else begin
                    exp_err++;
                    if (m_hv) emit(1'b1, 1'b1);
                    m_cnt = 0;
                    m_state = (b == 8'hC0) ? S_IDLE : S_HUNT;
                end
            end
        endcase
        if (dv) begin
            if (m_cnt == MAXL) begin
                exp_ovf++;
                if (m_hv) emit(1'b1, 1'b1);
                m_cnt = 0;
                m_state = S_HUNT;
            end else begin
                if (m_hv) emit(1'b0, 1'b0);
                m_h = d;
                m_hv = 1'b1;
                m_cnt++;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        mdl(b);
        rx.tdata = b;
        rx.tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx.tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rx.tready) begin
            checks++;
            fails++;
            $display("FAIL rx_timeout: got tready=0 exp tready=1 byte=%h", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rx.tvalid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
        idle();
    endtask

    task automatic send_enc(input logic [7:0] b);
        if (b == 8'hC0) begin
            send(8'hDB);
            send(8'hDC);
        end else if (b == 8'hDB) begin
            send(8'hDB);
            send(8'hDD);
        end else send(b);
    endtask

    task automatic drain_and_check(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fs.tvalid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_beats"}, beats_seen, beats_exp);
        chk({tag, "_err_pulses"}, seen_err, exp_err);
        chk({tag, "_ovf_pulses"}, seen_ovf, exp_ovf);
    endtask

    initial begin
        logic prev_stall;
        logic [9:0] prev_beat;
        logic [9:0] got;
        logic [9:0] e;
        prev_stall = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                got = {fs.tdata, fs.tlast, fs.tuser};
                if (prev_stall) begin
                    checks++;
                    if (!fs.tvalid || got != prev_beat) begin
                        fails++;
                        $display("FAIL hold_stable: got v=%0b %h exp v=1 %h",
                                 fs.tvalid, got, prev_beat);
                    end
                end
                if (fs.tvalid && fs.tready) begin
                    checks++;
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL beat_unexpected: got d=%h l=%0b u=%0b exp none",
                                 fs.tdata, fs.tlast, fs.tuser);
                    end else begin
                        e = exp_q.pop_front();
                        if (e != got) begin
                            fails++;
                            $display("FAIL beat: got d=%h l=%0b u=%0b exp d=%h l=%0b u=%0b",
                                     got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
                        end
                    end
                end
                if (ferr) seen_err++;
                if (fovf) seen_ovf++;
                if (ferr || fovf) begin
                    checks++;
                    if (ferr && fovf) begin
                        fails++;
                        $display("FAIL status_exclusive: got err=1 ovf=1 exp one of them");
                    end
                end
                prev_stall = fs.tvalid && !fs.tready;
                prev_beat = got;
            end
        end
    end

    initial begin
        logic [7:0] pl[$];
        int len;
        int r;
        rst_n = 1'b0;
        rx.tvalid = 1'b0;
        rx.tdata = '0;
        rx.tlast = 1'b0;
        rx.tuser = 1'b0;
        m_state = S_HUNT;
        m_hv = 1'b0;
        m_h = '0;
        m_cnt = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", int'(fs.tvalid), 0);
        chk("rst_tdata", int'(fs.tdata), 0);
        chk("rst_tlast", int'(fs.tlast), 0);
        chk("rst_tuser", int'(fs.tuser), 0);
        chk("rst_err", int'(ferr), 0);
        chk("rst_ovf", int'(fovf), 0);
        chk("rst_rx_tready", int'(rx.tready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_seq('{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0});
        drain_and_check("t1_basic");

        send_seq('{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h7E, 8'hC0});
        drain_and_check("t2_escape");

        send_seq('{8'hC0, 8'hC0, 8'hC0, 8'h05, 8'hC0});
        drain_and_check("t3_empty");

        send_seq('{8'hC0, 8'h11, 8'hDB, 8'h22, 8'h33, 8'hC0, 8'h44, 8'hC0});
        drain_and_check("t4_bad_esc");

        send_seq('{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'hC0, 8'hAA, 8'hC0});
        drain_and_check("t5_overflow");

        send_seq('{8'hDB, 8'hC0, 8'h66, 8'hC0});
        drain_and_check("t5b_esc_end");

        rnd_rdy = 1'b1;
        for (int f = 0; f < 50; f++) begin
            if (f == 25) begin
                rnd_rdy = 1'b0;
                send_seq('{8'hC0, 8'h31, 8'h32, 8'h33});
                drain_and_check("t6_pre_reset");
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                m_state = S_HUNT;
                m_hv = 1'b0;
                m_cnt = 0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                send_seq('{8'h77, 8'h88, 8'hC0, 8'h99, 8'hC0});
                drain_and_check("t6_post_reset");
                rnd_rdy = 1'b1;
            end
            len = $urandom_range(0, 6);
            pl.delete();
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 7);
                if (r == 0) pl.push_back(8'hC0);
                else if (r == 1) pl.push_back(8'hDB);
                else if (r == 2) pl.push_back(8'hDC);
                else pl.push_back(8'($urandom_range(0, 255)));
            end
            foreach (pl[i]) begin
                if ($urandom_range(0, 19) == 0) begin
                    send(8'hDB);
                    send(8'h41);
                end
                send_enc(pl[i]);
            end
            send(8'hC0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rnd_rdy = 1'b0;
        drain_and_check("t6_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
